iomem_port_arbiter: RTL and testbench

//  Shares the single data port of the I/O memory (RAM / encrypted album / decrypted tram, split by
//  the address decoder) between two requesters: the scalar CPU load/store unit (req 0) and the

---
 rtl/iomem_arb_pkg.sv | 20 ++
 rtl/iomem_rd_tag_pipe.sv | 37 +++
 rtl/iomem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_iomem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_arb_pkg.sv
// Shared types for the I/O memory port arbiter: owner encoding and the read-return tag.
package iomem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VEC  = 2'd2
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  // The requester that is not o; OWN_NONE maps to OWN_CPU so CPU wins a cold tie.
  function automatic owner_t other_of(input owner_t o);
    return (o == OWN_CPU) ? OWN_VEC : OWN_CPU;
  endfunction

endpackage

// File: rtl/iomem_rd_tag_pipe.sv
// Fixed-depth shift pipe that carries read tags alongside the memory's read latency.
module iomem_rd_tag_pipe
  import iomem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [DEPTH];
  rd_tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/iomem_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the I/O memory data port between the
// scalar CPU LSU and the vector LSU, with tagged return of synchronous read data.
module iomem_port_arbiter
  import iomem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vec_req,
  input  logic              vec_we,
  input  logic [ADDR_W-1:0] vec_addr,
  input  logic [DATA_W-1:0] vec_wdata,
  output logic              vec_gnt,
  output logic              vec_rvalid,
  output logic [DATA_W-1:0] vec_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_owner
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);

  // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt high in a
  // cycle; that cycle the access issues. Read data returns later as a one-cycle rvalid.
  owner_t             owner_q, owner_d;
  owner_t             last_q, last_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [DATA_W-1:0]  cpu_rdata_q, vec_rdata_q;
  owner_t             grant;
  logic               burst_full;
  rd_tag_t            tag_in, tag_out;
  logic               cpu_hit, vec_hit;

  assign burst_full = (burst_q == BURST_W'(MAX_BURST));
  assign dbg_owner  = owner_q;

  always_comb begin
    grant = OWN_NONE;
    case (owner_q)
      OWN_CPU: begin
        if (cpu_req && (!vec_req || !burst_full)) grant = OWN_CPU;
        else if (vec_req)                         grant = OWN_VEC;
      end
      OWN_VEC: begin
        if (vec_req && (!cpu_req || !burst_full)) grant = OWN_VEC;
        else if (cpu_req)                         grant = OWN_CPU;
      end
      default: begin
        if (cpu_req && vec_req) grant = other_of(last_q);
        else if (cpu_req)       grant = OWN_CPU;
        else if (vec_req)       grant = OWN_VEC;
      end
    endcase
  end

  always_comb begin
    owner_d = grant;
    last_d  = (grant == OWN_NONE) ? last_q : grant;
    burst_d = '0;
    if (grant != OWN_NONE) begin
      if (grant != owner_q)  burst_d = BURST_W'(1);
      else if (!burst_full)  burst_d = burst_q + BURST_W'(1);
      else                   burst_d = burst_q;
    end
  end

  always_comb begin
    cpu_gnt   = (grant == OWN_CPU);
    vec_gnt   = (grant == OWN_VEC);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (vec_gnt) begin
      mem_we    = vec_we;
      mem_addr  = vec_addr;
      mem_wdata = vec_wdata;
    end
  end

  always_comb begin
    tag_in.valid = (grant != OWN_NONE) && !mem_we;
    tag_in.owner = tag_in.valid ? grant : OWN_NONE;
  end

  iomem_rd_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Returned data passes straight through on the hit cycle, then is held for that requester.
  always_comb begin
    cpu_hit    = tag_out.valid && (tag_out.owner == OWN_CPU);
    vec_hit    = tag_out.valid && (tag_out.owner == OWN_VEC);
    cpu_rvalid = cpu_hit;
    vec_rvalid = vec_hit;
    cpu_rdata  = cpu_hit ? mem_rdata : cpu_rdata_q;
    vec_rdata  = vec_hit ? mem_rdata : vec_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      last_q      <= OWN_VEC;
      burst_q     <= '0;
      cpu_rdata_q <= '0;
      vec_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      cpu_rdata_q <= cpu_rdata;
      vec_rdata_q <= vec_rdata;
    end
  end

endmodule

// File: tb/tb_iomem_port_arbiter.sv
// Directed bench for iomem_port_arbiter with a small synchronous memory model.
module tb_iomem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, cpu_we, vec_req, vec_we;
  logic [ADDR_W-1:0] cpu_addr, vec_addr;
  logic [DATA_W-1:0] cpu_wdata, vec_wdata;
  logic              cpu_gnt, cpu_rvalid, vec_gnt, vec_rvalid;
  logic [DATA_W-1:0] cpu_rdata, vec_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbg_owner;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  iomem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .MAX_BURST    (4),
    .READ_LATENCY (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .vec_req    (vec_req),
    .vec_we     (vec_we),
    .vec_addr   (vec_addr),
    .vec_wdata  (vec_wdata),
    .vec_gnt    (vec_gnt),
    .vec_rvalid (vec_rvalid),
    .vec_rdata  (vec_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_owner  (dbg_owner)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Memory model: fixed contents per address plus one write-back slot, read latency 1.
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr  = '0;
  logic [DATA_W-1:0] wr_data  = '0;
  logic [DATA_W-1:0] rd_q     = '0;

  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    case (a)
      32'h0000_0010: return 32'hDEAD_BEEF;
      32'h0000_0040: return 32'hA1A1_A1A1;
      32'h0000_0044: return 32'hC3C3_C3C3;
      32'h0000_0080: return 32'hB2B2_B2B2;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      wr_valid <= 1'b1;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
    end
    if ((cpu_gnt || vec_gnt) && !mem_we)
      rd_q <= (wr_valid && (mem_addr == wr_addr)) ? wr_data : data_of(mem_addr);
  end
  assign mem_rdata = rd_q;

  // Checkers
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vec_req = 1'b0; vec_we = 1'b0; vec_addr = '0; vec_wdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_cpu_gnt"}, cpu_gnt, 1'b0);
    chk1({tag, "_vec_gnt"}, vec_gnt, 1'b0);
    chk1({tag, "_cpu_rvalid"}, cpu_rvalid, 1'b0);
    chk1({tag, "_vec_rvalid"}, vec_rvalid, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk32({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk32({tag, "_vec_rdata"}, vec_rdata, 32'h0);
    chk32({tag, "_owner"}, 32'(dbg_owner), 32'h0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #1;
    do_reset();

    // 1: lone CPU read of 0x10
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h10;
    #2;
    chk1("t1_cpu_gnt", cpu_gnt, 1'b1);
    chk1("t1_vec_gnt", vec_gnt, 1'b0);
    chk1("t1_mem_we", mem_we, 1'b0);
    chk32("t1_mem_addr", mem_addr, 32'h10);
    tick();
    idle();
    #2;
    chk1("t1_cpu_rvalid", cpu_rvalid, 1'b1);
    chk32("t1_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk1("t1_vec_rvalid", vec_rvalid, 1'b0);
    tick();
    #2;
    chk1("t1_cpu_rvalid_off", cpu_rvalid, 1'b0);
    chk32("t1_cpu_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

    // 2: both requesting continuously from reset: CPU x4, VEC x4, ...
    do_reset();
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h200;
    vec_req = 1'b1; vec_addr = 32'h300;
    for (int i = 0; i < 16; i++) begin
      #2;
      chk1($sformatf("t2_cpu_gnt_%0d", i), cpu_gnt, ((i / 4) % 2) == 0);
      chk1($sformatf("t2_vec_gnt_%0d", i), vec_gnt, ((i / 4) % 2) == 1);
      tick();
    end
    idle();
    tick();
    tick();

    // 3: VEC alone for 10 cycles, burst saturates without a forced switch
    vec_req = 1'b1; vec_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk1($sformatf("t3_vec_gnt_%0d", i), vec_gnt, 1'b1);
      chk1($sformatf("t3_cpu_gnt_%0d", i), cpu_gnt, 1'b0);
      tick();
    end
    idle();
    tick();
    tick();

    // 4: alternating reads CPU@0x40, VEC@0x80, CPU@0x44
    cpu_req = 1'b1; cpu_addr = 32'h40;
    #2;
    chk1("t4_c0_cpu_gnt", cpu_gnt, 1'b1);
    chk32("t4_c0_mem_addr", mem_addr, 32'h40);
    exp_q.push_back(32'hA1A1_A1A1);
    tick();
    idle();
    vec_req = 1'b1; vec_addr = 32'h80;
    #2;
    chk1("t4_c1_vec_gnt", vec_gnt, 1'b1);
    chk1("t4_c1_cpu_gnt", cpu_gnt, 1'b0);
    chk1("t4_c1_cpu_rvalid", cpu_rvalid, 1'b1);
    chk1("t4_c1_vec_rvalid", vec_rvalid, 1'b0);
    chk32("t4_c1_cpu_rdata", cpu_rdata, exp_q.pop_front());
    exp_q.push_back(32'hB2B2_B2B2);
    tick();
    idle();
    cpu_req = 1'b1; cpu_addr = 32'h44;
    #2;
    chk1("t4_c2_cpu_gnt", cpu_gnt, 1'b1);
    chk1("t4_c2_vec_rvalid", vec_rvalid, 1'b1);
    chk1("t4_c2_cpu_rvalid", cpu_rvalid, 1'b0);
    chk32("t4_c2_vec_rdata", vec_rdata, exp_q.pop_front());
    chk32("t4_c2_cpu_rdata_hold", cpu_rdata, 32'hA1A1_A1A1);
    exp_q.push_back(32'hC3C3_C3C3);
    tick();
    idle();
    #2;
    chk1("t4_c3_cpu_rvalid", cpu_rvalid, 1'b1);
    chk1("t4_c3_vec_rvalid", vec_rvalid, 1'b0);
    chk32("t4_c3_cpu_rdata", cpu_rdata, exp_q.pop_front());
    chk32("t4_c3_vec_rdata_hold", vec_rdata, 32'hB2B2_B2B2);
    chk32("t4_queue_empty", exp_q.size(), 32'd0);
    tick();

    // 5: VEC write then CPU read of the same address
    vec_req = 1'b1; vec_we = 1'b1; vec_addr = 32'h100; vec_wdata = 32'h1234_5678;
    #2;
    chk1("t5_vec_gnt", vec_gnt, 1'b1);
    chk1("t5_mem_we", mem_we, 1'b1);
    chk32("t5_mem_addr", mem_addr, 32'h100);
    chk32("t5_mem_wdata", mem_wdata, 32'h1234_5678);
    tick();
    idle();
    cpu_req = 1'b1; cpu_addr = 32'h100;
    #2;
    chk1("t5_cpu_gnt", cpu_gnt, 1'b1);
    chk1("t5_mem_we_rd", mem_we, 1'b0);
    chk1("t5_no_write_rvalid", vec_rvalid, 1'b0);
    tick();
    idle();
    #2;
    chk1("t5_cpu_rvalid", cpu_rvalid, 1'b1);
    chk32("t5_cpu_rdata", cpu_rdata, 32'h1234_5678);
    chk1("t5_mem_we_idle", mem_we, 1'b0);
    tick();

    // 6: reset one cycle after a CPU read issues discards the pending return
    cpu_req = 1'b1; cpu_addr = 32'h10;
    #2;
    chk1("t6_cpu_gnt", cpu_gnt, 1'b1);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_in_reset");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk1($sformatf("t6_cpu_rvalid_%0d", i), cpu_rvalid, 1'b0);
      chk1($sformatf("t6_vec_rvalid_%0d", i), vec_rvalid, 1'b0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
